// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port peripheral: register map and default width.
package gpio_pkg;

    localparam int GPIO_DEFAULT_WIDTH = 32;

    localparam logic [1:0] GPIO_DIR        = 2'd0;
    localparam logic [1:0] GPIO_DATA       = 2'd1;
    localparam logic [1:0] GPIO_IRQ_EN     = 2'd2;
    localparam logic [1:0] GPIO_IRQ_STATUS = 2'd3;

endpackage

// File: rtl/gpio_port_debouncer.sv
// Vector-wide input conditioner: 2-FF synchroniser, per-bit sample history and
// debounced level register. Sampling is paced by an external tick; DEB_DEPTH >= 2.
module port_debouncer #(
    parameter int WIDTH     = 32,
    parameter int DEB_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] deb_o
);

    logic [WIDTH-1:0]                sync1_q, sync2_q;
    logic [WIDTH-1:0]                deb_q, deb_d;
    logic [WIDTH-1:0][DEB_DEPTH-1:0] hist_q, hist_d;

    // A bit only changes level once its whole history agrees; mixed history holds it.
    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick_i) begin
                hist_d[i] = {hist_q[i][DEB_DEPTH-2:0], sync2_q[i]};
            end
            if (&hist_q[i]) begin
                deb_d[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                deb_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            deb_q   <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped bidirectional GPIO port: direction/data registers, tri-state pin
// drive, debounced inputs and sticky rising-edge interrupts.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH = GPIO_DEFAULT_WIDTH,
    parameter int DEB_CYCLES = 1,
    parameter int DEB_DEPTH  = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  wr,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  irq,
    inout  wire  [DATA_WIDTH-1:0] port_io
);

    localparam int             CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  TICK_AT = CW'(DEB_CYCLES - 1);

    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] outLatch_q, outLatch_d;
    logic [DATA_WIDTH-1:0] irqEn_q, irqEn_d;
    logic [DATA_WIDTH-1:0] irqStatus_q, irqStatus_d;
    logic [DATA_WIDTH-1:0] debPrev_q;
    logic [DATA_WIDTH-1:0] debounced;
    logic [DATA_WIDTH-1:0] riseEvent;
    logic [CW-1:0]         preCnt_q, preCnt_d;
    logic                  tick;
    logic                  wrEn;

    assign tick = (preCnt_q == TICK_AT);
    assign wrEn = ce & wr;

    port_debouncer #(
        .WIDTH     (DATA_WIDTH),
        .DEB_DEPTH (DEB_DEPTH)
    ) u_debouncer (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .tick_i (tick),
        .pin_i  (port_io),
        .deb_o  (debounced)
    );

    // Only input-direction, enabled bits may raise status; a same-edge set beats the W1C clear.
    always_comb begin
        dir_d       = dir_q;
        outLatch_d  = outLatch_q;
        irqEn_d     = irqEn_q;
        irqStatus_d = irqStatus_q;
        preCnt_d    = tick ? '0 : preCnt_q + 1'b1;
        riseEvent   = debounced & ~debPrev_q & ~dir_q & irqEn_q;
        if (wrEn) begin
            case (addr)
                GPIO_DIR:        dir_d       = data_in;
                GPIO_DATA:       outLatch_d  = data_in;
                GPIO_IRQ_EN:     irqEn_d     = data_in;
                GPIO_IRQ_STATUS: irqStatus_d = irqStatus_q & ~data_in;
                default:         ;
            endcase
        end
        irqStatus_d = irqStatus_d | riseEvent;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= '0;
            outLatch_q  <= '0;
            irqEn_q     <= '0;
            irqStatus_q <= '0;
            debPrev_q   <= '0;
            preCnt_q    <= '0;
        end else begin
            dir_q       <= dir_d;
            outLatch_q  <= outLatch_d;
            irqEn_q     <= irqEn_d;
            irqStatus_q <= irqStatus_d;
            debPrev_q   <= debounced;
            preCnt_q    <= preCnt_d;
        end
    end

    always_comb begin
        data_out = '0;
        if (ce) begin
            case (addr)
                GPIO_DIR:        data_out = dir_q;
                GPIO_DATA:       data_out = (outLatch_q & dir_q) | (debounced & ~dir_q);
                GPIO_IRQ_EN:     data_out = irqEn_q;
                GPIO_IRQ_STATUS: data_out = irqStatus_q;
                default:         data_out = '0;
            endcase
        end
    end

    assign irq = |(irqStatus_q & irqEn_q);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        assign port_io[i] = dir_q[i] ? outLatch_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port: register defaults, pin drive,
// debounce latency, glitch rejection, interrupt status handling and async reset.
module tb_gpio_port;
    import gpio_pkg::*;

    logic        sys_clk;
    logic        rst_n;
    logic        ce;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;
    wire  [31:0] port_io;

    logic [31:0] tbEn;
    logic [31:0] tbVal;
    logic [31:0] rd;
    int          testsRun;
    int          testsFailed;

    gpio_port #(
        .DATA_WIDTH (32),
        .DEB_CYCLES (1),
        .DEB_DEPTH  (3)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .port_io  (port_io)
    );

    // The board side drives a pin only where its enable is set.
    for (genvar i = 0; i < 32; i++) begin : g_board
        assign port_io[i] = tbEn[i] ? tbVal[i] : 1'bz;
    end

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        ce   = 1'b1;
        wr   = 1'b0;
        addr = a;
        #1;
        d  = data_out;
        ce = 1'b0;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        ce      = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge sys_clk);
        ce      = 1'b0;
        wr      = 1'b0;
        data_in = '0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n   = 1'b0;
        ce      = 1'b0;
        wr      = 1'b0;
        addr    = 2'd0;
        data_in = '0;
        tbEn    = '0;
        tbVal   = '0;

        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        readReg(GPIO_DIR, rd);        checkOutput("rst_dir", rd, 32'h0);
        readReg(GPIO_DATA, rd);       checkOutput("rst_data", rd, 32'h0);
        readReg(GPIO_IRQ_EN, rd);     checkOutput("rst_en", rd, 32'h0);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("rst_status", rd, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        testsRun++;
        assert (port_io === {32{1'bz}})
        else begin
            testsFailed++;
            $error("[TB] FAIL rst_pins: observed %h expected all z", port_io);
        end

        // Output drive on pins 7:4
        writeReg(GPIO_DIR, 32'h0000_00F0);
        writeReg(GPIO_DATA, 32'h0000_00A0);
        testsRun++;
        assert (port_io === {24'hzzzzzz, 4'hA, 4'hz})
        else begin
            testsFailed++;
            $error("[TB] FAIL drive_pins: observed %h expected zzzzzzAz", port_io);
        end
        tbEn  = 32'h0000_000F;
        tbVal = 32'h0;
        repeat (8) @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("drive_data", rd, 32'h0000_00A0);
        ce   = 1'b0;
        addr = GPIO_DATA;
        #1;
        checkOutput("ce_low_zero", data_out, 32'h0);

        // Button press on pin 3: high for 5 cycles
        writeReg(GPIO_IRQ_EN, 32'h8);
        tbVal[3] = 1'b1;
        repeat (5) @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("btn_deb_early", rd, 32'h0000_00A0);
        tbVal[3] = 1'b0;
        @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("btn_deb_rise", rd, 32'h0000_00A8);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("btn_status_early", rd, 32'h0);
        checkOutput("btn_irq_early", {31'h0, irq}, 32'h0);
        @(negedge sys_clk);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("btn_status", rd, 32'h8);
        checkOutput("btn_irq", {31'h0, irq}, 32'h1);
        repeat (8) @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("btn_deb_fall", rd, 32'h0000_00A0);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("btn_status_hold", rd, 32'h8);
        checkOutput("btn_irq_hold", {31'h0, irq}, 32'h1);
        writeReg(GPIO_IRQ_STATUS, 32'h8);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("btn_w1c", rd, 32'h0);
        checkOutput("btn_irq_clr", {31'h0, irq}, 32'h0);

        // Two-cycle glitch on pin 2
        writeReg(GPIO_IRQ_EN, 32'h4);
        tbVal[2] = 1'b1;
        repeat (2) @(negedge sys_clk);
        tbVal[2] = 1'b0;
        repeat (10) @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("glitch_data", rd, 32'h0000_00A0);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("glitch_status", rd, 32'h0);
        checkOutput("glitch_irq", {31'h0, irq}, 32'h0);

        // Set and W1C clear of bit 0 on the same edge
        writeReg(GPIO_IRQ_EN, 32'h1);
        tbVal[0] = 1'b1;
        repeat (6) @(negedge sys_clk);
        readReg(GPIO_DATA, rd);       checkOutput("coll_deb", rd, 32'h0000_00A1);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("coll_status_pre", rd, 32'h0);
        writeReg(GPIO_IRQ_STATUS, 32'h1);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("coll_status", rd, 32'h1);
        checkOutput("coll_irq", {31'h0, irq}, 32'h1);
        writeReg(GPIO_IRQ_EN, 32'h0);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("en_off_status", rd, 32'h1);
        checkOutput("en_off_irq", {31'h0, irq}, 32'h0);
        writeReg(GPIO_IRQ_EN, 32'h1);
        checkOutput("en_on_irq", {31'h0, irq}, 32'h1);

        // Async reset in the middle of a debounce
        tbEn  = '0;
        tbVal = '0;
        writeReg(GPIO_DIR, 32'h0000_00FF);
        testsRun++;
        assert (port_io === {24'hzzzzzz, 8'hA0})
        else begin
            testsFailed++;
            $error("[TB] FAIL ff_pins: observed %h expected zzzzzzA0", port_io);
        end
        tbEn[8]  = 1'b1;
        tbVal[8] = 1'b1;
        repeat (2) @(negedge sys_clk);
        checkOutput("pre_rst_irq", {31'h0, irq}, 32'h1);
        tbEn = '0;
        #5;
        rst_n = 1'b0;
        #1;
        testsRun++;
        assert (port_io === {32{1'bz}})
        else begin
            testsFailed++;
            $error("[TB] FAIL arst_pins: observed %h expected all z", port_io);
        end
        checkOutput("arst_irq", {31'h0, irq}, 32'h0);
        #2;
        rst_n = 1'b1;
        @(negedge sys_clk);
        readReg(GPIO_DIR, rd);        checkOutput("arst_dir", rd, 32'h0);
        readReg(GPIO_DATA, rd);       checkOutput("arst_data", rd, 32'h0);
        readReg(GPIO_IRQ_EN, rd);     checkOutput("arst_en", rd, 32'h0);
        readReg(GPIO_IRQ_STATUS, rd); checkOutput("arst_status", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Memory-mapped bidirectional I/O port peripheral inside the MIPS microcontroller.
- It is the device-side end of the `port_io` bus that the board (or bench) drives with buttons and reads for LEDs.
- Function:
  - per-bit direction control and output drive of the tri-state pins;
  - synchronisation and debouncing of pin inputs;
  - rising-edge interrupt generation for the CPU.
- It sits on the data-memory bus beside RAM and is selected by the address decoder via `ce`.

Parameters:
- DATA_WIDTH, 32, number of port pins and register width.
- DEB_CYCLES, 1, clock cycles per debounce sample tick (1 = sample every cycle).
- DEB_DEPTH, 3, consecutive equal samples required to accept a new input level.

Ports:
- sys_clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  peripheral select from the address decoder.
- wr  input  1  1 = write, 0 = read; qualified by ce.
- addr  input  2  register select.
- data_in  input  DATA_WIDTH  write data from the CPU.
- data_out  output  DATA_WIDTH  read data; combinational, 0 when ce = 0.
- irq  output  1  interrupt request to the CPU, level.
- port_io  inout  DATA_WIDTH  external pins.

Behaviour:
- Registers:
  - addr 0, PORT_DIR: 1 = output, 0 = input. Reset 0, all inputs.
  - addr 1, PORT_DATA:
    - write loads the output latch (reset 0);
    - read returns the output latch on bits with dir = 1 and the debounced input on bits with dir = 0.
  - addr 2, IRQ_EN: per-bit interrupt enable. Reset 0.
  - addr 3, IRQ_STATUS: sticky, write-1-to-clear. Reset 0.
- Writes take effect on the sys_clk edge where ce = 1 and wr = 1.
- Reads are combinational the same cycle, matching the single-cycle datapath.
- Pin drive: `port_io[i]` = output latch[i] when dir[i] = 1, else Z. A dir write changes pin drive on the next edge.
- Input path, per bit:
  - 2-FF synchroniser.
  - Shared prescaler counting 0..DEB_CYCLES-1 generates a tick.
  - On each tick, the synchronised value shifts into a DEB_DEPTH-deep history.
  - The debounced bit becomes 1 when the history is all ones and 0 when it is all zeros; otherwise it holds.
  - With defaults, the debounced bit reflects a stable pin change exactly DEB_DEPTH + 2 = 5 cycles after the first edge that samples it.
- Glitch rule: a pin pulse shorter than DEB_DEPTH ticks never changes the debounced value.
- Edge detect:
  - `status[i]` sets on the edge after debounced[i] goes 0 to 1, provided dir[i] = 0 and en[i] = 1 at that edge.
  - Falling edges are ignored.
  - Bits with dir = 1 never set status, even though their debounce logic follows the driven pin.
- Simultaneous set and W1C clear of the same bit: set wins, the bit stays 1.
- Clearing en[i] does not clear status[i]; the status bit holds until written with a 1.
- `irq` = OR over i of (status[i] AND en[i]), combinational from registers. Reset value 0.
- Reset assertion, including mid-debounce or mid-write:
  - all registers, histories, synchronisers and the prescaler clear immediately;
  - pins tri-state immediately;
  - irq = 0.
- Debounced values restart at 0. A pin held high through reset produces a rising edge after release; that edge is only counted if en is set by then.
- Prescaler wrap: the tick fires on count DEB_CYCLES-1, and the counter then returns to 0.

Decomposition:
- Shared package `gpio_pkg` holds:
  - register address constants GPIO_DIR = 2'd0, GPIO_DATA = 2'd1, GPIO_IRQ_EN = 2'd2, GPIO_IRQ_STATUS = 2'd3;
  - the default DATA_WIDTH.
- One sub-module: `port_debouncer`, a vector-wide synchroniser plus history plus debounced register, parameterised by DEB_DEPTH. It takes the tick as an input. The prescaler stays in gpio_port.

Test Plan:
- Reset defaults: hold rst_n = 0 for 3 cycles, release, read all four registers.
  - Required: all reads 0, irq = 0, `port_io` all Z.
- Output drive: write DIR = 0x000000F0, then DATA = 0x000000A0.
  - Required: `port_io[7:4]` = 4'hA on the next edge; other bits Z.
  - Required: reading DATA with bits 3:0 externally 0 returns 0x000000A0.
- Button interrupt: write IRQ_EN = 0x8, then drive `port_io[3]` = 1 for 5 cycles (100 ns at 20 ns period) and release.
  - Required: debounced bit 3 rises 5 cycles after the press, STATUS = 0x8 one edge later, irq = 1.
  - Required: irq stays 1 after release.
  - Required: writing STATUS = 0x8 clears it and drops irq.
- Glitch rejection: drive `port_io[2]` = 1 for 2 cycles with IRQ_EN = 0x4.
  - Required: DATA bit 2 stays 0, STATUS = 0, irq = 0.
- Set/clear collision: with en[0] = 1, schedule a W1C write of STATUS = 0x1 on the same edge that bit 0's rising edge is detected.
  - Required: STATUS reads 0x1 afterwards and irq = 1.
- Async reset mid-operation: with DIR = 0xFF and a debounce in progress, pulse rst_n low between clock edges.
  - Required: pins go Z and irq goes 0 before the next edge; all registers read 0.
